// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 Set-2 scancode controller.
//   ps2_event_t   : one parsed key event {code, ext, brk}
//   ack_state_t   : irq/clear_keycode acknowledge FSM states
//   parse_state_t : Set-2 prefix parser states
//   ps2_is_discard: true for controller/status bytes that carry no key event
package ps2_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_ACK  = 1'b1
  } ack_state_t;

  typedef enum logic [2:0] {
    P_BASE   = 3'd0,
    P_EXT    = 3'd1,
    P_BRK    = 3'd2,
    P_EXTBRK = 3'd3,
    P_SKIP   = 3'd4
  } parse_state_t;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_LEN = 3'd7;

  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_ERR0      = 8'h00;
  localparam logic [7:0] PS2_ERRF      = 8'hFF;

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic r;
    case (b)
      PS2_BAT_OK, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_ERR0, PS2_ERRF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO of ps2_event_t with a registered head.
// Ports: clock, reset (sync, active-high); i_push/i_push_ev write side;
//   i_pop read side (ignored when empty); o_head registered head entry;
//   o_full, o_empty flags; o_count entries queued (0..DEPTH).
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  ps2_event_t    i_push_ev,
  input  logic          i_pop,
  output ps2_event_t    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  ps2_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_vld;
  ps2_event_t    r_head;

  logic          w_full;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_remaining;
  logic [CW-1:0] w_count_next;
  ps2_event_t    w_head_next;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop & r_head_vld;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  // Next head: the pushed entry when the FIFO would otherwise drain, else memory.
  always_comb begin
    w_rd_next    = w_pop_ok ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_remaining  = r_count - CW'(w_pop_ok);
    w_count_next = w_remaining + CW'(w_push_ok);
    if (w_remaining == CW'(0)) begin
      w_head_next = w_push_ok ? i_push_ev : r_head;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Storage, pointers, count and registered head.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_ev;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_count_next;
      r_head_vld <= (w_count_next != CW'(0));
      r_head     <= w_head_next;
    end
  end

  assign o_head  = r_head;
  assign o_full  = w_full;
  assign o_empty = ~r_head_vld;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: acknowledges KFPS2KB bytes, parses Set-2 prefixes
// (E0 extended, F0 break, E1 pause) into single key events and queues them.
// Ports: clock, reset (sync, active-high); irq/keycode from KFPS2KB,
//   clear_keycode acknowledge back; event_valid/event_ready handshake with
//   event_code/event_ext/event_break head fields; overflow sticky drop flag;
//   fifo_count queued entries.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses typematic repeats
//   (a make identical to the currently held key).
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          irq,
  input  logic [7:0]    keycode,
  output logic          clear_keycode,
  output logic          event_valid,
  input  logic          event_ready,
  output logic [7:0]    event_code,
  output logic          event_ext,
  output logic          event_break,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  ack_state_t   r_ack_state, w_ack_next;
  logic         w_latch;
  logic [7:0]   r_byte_q;
  logic         r_byte_vld;
  logic         r_clear;

  parse_state_t r_pstate, w_pnext;
  logic [2:0]   r_skip_cnt, w_skip_next;
  logic         w_emit;
  ps2_event_t   w_emit_ev;
  logic         w_suppress;

  logic         r_push;
  ps2_event_t   r_push_ev;
  logic         r_overflow;

  ps2_event_t   w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;

  // Acknowledge FSM: latch one byte per irq assertion, hold ack until irq drops.
  always_comb begin
    w_ack_next = r_ack_state;
    w_latch    = 1'b0;
    case (r_ack_state)
      ACK_IDLE: begin
        if (irq) begin
          w_ack_next = ACK_ACK;
          w_latch    = 1'b1;
        end else begin
          w_ack_next = ACK_IDLE;
        end
      end
      ACK_ACK: begin
        if (!irq) begin
          w_ack_next = ACK_IDLE;
        end else begin
          w_ack_next = ACK_ACK;
        end
      end
      default: w_ack_next = ACK_IDLE;
    endcase
  end

  // Acknowledge state, latched byte and its one-cycle valid strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack_state <= ACK_IDLE;
      r_clear     <= 1'b0;
      r_byte_q    <= 8'h00;
      r_byte_vld  <= 1'b0;
    end else begin
      r_ack_state <= w_ack_next;
      r_clear     <= (w_ack_next == ACK_ACK);
      r_byte_vld  <= w_latch;
      if (w_latch) begin
        r_byte_q <= keycode;
      end else begin
        r_byte_q <= r_byte_q;
      end
    end
  end

  // Prefix parser: runs only on the strobe cycle after a byte is latched.
  always_comb begin
    w_pnext     = r_pstate;
    w_skip_next = r_skip_cnt;
    w_emit      = 1'b0;
    w_emit_ev   = '{code: r_byte_q, ext: 1'b0, brk: 1'b0};
    if (r_byte_vld) begin
      case (r_pstate)
        P_BASE, P_EXT: begin
          if (r_byte_q == PS2_PFX_EXT) begin
            w_pnext = P_EXT;
          end else if (r_byte_q == PS2_PFX_PAUSE) begin
            w_pnext     = P_SKIP;
            w_skip_next = PS2_PAUSE_LEN;
          end else if (r_byte_q == PS2_PFX_BRK) begin
            w_pnext = (r_pstate == P_EXT) ? P_EXTBRK : P_BRK;
          end else if ((r_pstate == P_BASE) && ps2_is_discard(r_byte_q)) begin
            w_pnext = P_BASE;
          end else begin
            w_emit        = 1'b1;
            w_emit_ev.ext = (r_pstate == P_EXT);
            w_pnext       = P_BASE;
          end
        end
        P_BRK, P_EXTBRK: begin
          w_emit        = 1'b1;
          w_emit_ev.ext = (r_pstate == P_EXTBRK);
          w_emit_ev.brk = 1'b1;
          w_pnext       = P_BASE;
        end
        P_SKIP: begin
          // The seventh byte after E1 closes the pause sequence.
          if (r_skip_cnt == 3'd1) begin
            w_emit      = 1'b1;
            w_emit_ev   = '{code: PS2_PFX_PAUSE, ext: 1'b1, brk: 1'b0};
            w_skip_next = 3'd0;
            w_pnext     = P_BASE;
          end else begin
            w_skip_next = r_skip_cnt - 3'd1;
          end
        end
        default: begin
          w_pnext     = P_BASE;
          w_skip_next = 3'd0;
        end
      endcase
    end else begin
      w_pnext     = r_pstate;
      w_skip_next = r_skip_cnt;
    end
  end

  // Parser state and skip counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pstate   <= P_BASE;
      r_skip_cnt <= 3'd0;
    end else begin
      r_pstate   <= w_pnext;
      r_skip_cnt <= w_skip_next;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_last_vld;
  logic [8:0] r_last_key;

  assign w_suppress = w_emit & ~w_emit_ev.brk & r_last_vld &
                      (r_last_key == {w_emit_ev.code, w_emit_ev.ext});

  // Held-key tracker: a make records the key, any break forgets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_vld <= 1'b0;
      r_last_key <= 9'h000;
    end else if (w_emit) begin
      r_last_vld <= ~w_emit_ev.brk;
      r_last_key <= {w_emit_ev.code, w_emit_ev.ext};
    end else begin
      r_last_vld <= r_last_vld;
      r_last_key <= r_last_key;
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  // Registered push request and sticky overflow on a dropped event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_push     <= 1'b0;
      r_push_ev  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_push     <= w_emit & ~w_suppress;
      r_push_ev  <= w_emit_ev;
      r_overflow <= r_overflow | (r_push & w_full & ~w_pop);
    end
  end

  assign w_pop = event_ready & ~w_empty;

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (r_push),
    .i_push_ev (r_push_ev),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  assign clear_keycode = r_clear;
  assign event_valid   = ~w_empty;
  assign event_code    = w_head.code;
  assign event_ext     = w_head.ext;
  assign event_break   = w_head.brk;
  assign overflow      = r_overflow;

endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
Sequencer between the KFPS2KB receiver and downstream consumers (display/CPU mailbox). Drives the irq/clear_keycode acknowledge handshake and parses Set-2 prefix bytes (E0, F0, E1) into single key events. Queues events in a small FIFO with a valid/ready output. Replaces ad-hoc keycode shift registers in top-level glue.

Parameters:
DEPTH, 8, event FIFO entries; power of two, minimum 2
CW, $clog2(DEPTH)+1, width of fifo_count (derived, not overridable)

Ports:
clock  input  1  system clock (PLL output domain)
reset  input  1  synchronous, active-high reset
irq  input  1  KFPS2KB byte-available flag; stays high until acknowledged
keycode  input  8  KFPS2KB received byte; valid while irq=1
clear_keycode  output  1  acknowledge to KFPS2KB
event_valid  output  1  FIFO head holds an event
event_ready  input  1  consumer accepts head this cycle
event_code  output  8  base scancode of head event
event_ext  output  1  head event had E0 prefix (or is Pause)
event_break  output  1  head event is a release (F0 prefix)
overflow  output  1  sticky: an event was dropped on full FIFO
fifo_count  output  CW  entries currently queued

Behaviour:
- Synchronous active-high reset, applied at every clock edge. After reset: clear_keycode=0, event_valid=0, event_code=8'h00, event_ext=0, event_break=0, overflow=0, fifo_count=0. Acknowledge FSM goes to IDLE and parser goes to P_BASE.
- Reset mid-byte or mid-prefix discards the partial sequence and clears the FIFO.
- Acknowledge FSM:
  - IDLE: if irq=1, latch keycode into byte_q, go to ACK.
  - ACK: clear_keycode=1. Stay while irq=1. Go to IDLE when irq=0.
  - Each byte is consumed exactly once, however long irq stays high.
- Parser runs one cycle after the latch (the ACK entry cycle). States:
  - P_BASE:
    - E0 -> P_EXT
    - F0 -> P_BRK
    - E1 -> P_SKIP with skip_cnt=7
    - AA, FA, FE, EE, 00, FF -> discarded, stay in P_BASE
    - any other byte -> push {code, ext=0, brk=0}
  - P_EXT: F0 -> P_EXTBRK; E0/E1 -> restart the prefix as from P_BASE; other -> push {code, 1, 0}, go to P_BASE.
  - P_BRK: any byte -> push {code, 0, 1}, go to P_BASE.
  - P_EXTBRK: any byte -> push {code, 1, 1}, go to P_BASE. E0 F0 12 (fake shift) is pushed like any other code; no special handling.
  - P_SKIP: decrement skip_cnt per byte. On the byte where skip_cnt reaches 0, push {8'hE1, 1, 0} and go to P_BASE. Pause thus yields exactly one event.
- Latency: irq sampled high at edge N -> event_valid=1 after edge N+2 when the FIFO was empty.
- FIFO:
  - Pop when event_valid & event_ready; the head is registered.
  - Push with fifo_count==DEPTH and no pop in the same cycle: event dropped, overflow set and held until reset.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- The parser never stalls on a full FIFO; byte acknowledgement continues.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined:
  - A last_make register ({code, ext} plus a valid bit) suppresses a make event identical to the held key. Typematic repeats are not pushed.
  - Any break event, or a make of a different key, updates or clears last_make.
  - Reset clears the valid bit.
- Undefined: every make is pushed, and the register and logic are absent.

Decomposition:
- Package ps2_pkg holds:
  - typedef struct packed {logic [7:0] code; logic ext; logic brk;} ps2_event_t
  - enums ack_state_t and parse_state_t
  - localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_LEN=7, plus the discard-code constants
- One sub-module, ps2_event_fifo: synchronous FIFO of ps2_event_t, parameter DEPTH, ports push/pop/full/empty/count.

Test Plan:
- Byte 1C with irq held high for 40 cycles -> exactly one event {1C,0,0}; clear_keycode high until irq falls; event_valid high 2 cycles after irq is sampled.
- Bytes F0,1C -> one event {1C,0,1}; E0,F0,75 -> one event {75,1,1}; E0,75 -> {75,1,0}.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> single event {E1,1,0}; parser back in P_BASE, so the next byte 1C gives {1C,0,0}.
- DEPTH=8, event_ready=0, 9 make codes -> fifo_count=8, overflow=1, first 8 codes pop out in order. Then pop and push in the same cycle while full -> count stays 8.
- Reset asserted after E0 and before 75 -> all outputs at reset values. Next byte 75 -> {75,0,0}.
- With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events {1C,0,0},{1C,0,1},{1C,0,0}. Without it -> five events.
